// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp: 2-read / 1-write byte-masked register file with clear sequencer.
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DATA_D   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic [ADDR_W-1:0]   rd0_addr,
    output logic [DATA_W-1:0]   rd0_data,
    input  logic [ADDR_W-1:0]   rd1_addr,
    output logic [DATA_W-1:0]   rd1_data,
    input  logic                we_,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be_,
    input  logic                clr_req_,
    output logic                busy
);

    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt, cnt_nxt;
    logic [DATA_W-1:0]   entries [DATA_D];
    logic [DATA_W-1:0]   be_mask;
    logic                wr_ok;
    logic [ADDR_W-1:0]   rd_addr [2];
    logic [DATA_W-1:0]   rd_data [2];

    // An address is usable when it maps to real storage and is not the hard zero entry.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < DATA_D) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    for (genvar b = 0; b < NBYTES; b++) begin : g_mask
        assign be_mask[8*b +: 8] = {8{~wr_be_[b]}};
    end

    assign wr_ok = !we_ && (state == IDLE) && addr_ok(wr_addr);
    assign busy  = (state == CLEAR);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (!clr_req_) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == ADDR_W'(DATA_D - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    for (genvar e = 0; e < DATA_D; e++) begin : g_entry
        logic [DATA_W-1:0] q;
        always_ff @(posedge clk or negedge reset_) begin
            if (!reset_) begin
                q <= '0;
            end else if ((state == CLEAR) && (cnt == ADDR_W'(e))) begin
                q <= '0;
            end else if (wr_ok && (wr_addr == ADDR_W'(e))) begin
                q <= (wr_data & be_mask) | (q & ~be_mask);
            end
        end
        assign entries[e] = q;
    end

    assign rd_addr[0] = rd0_addr;
    assign rd_addr[1] = rd1_addr;

    // Range and zero-register forcing win over the write bypass.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            if (addr_ok(rd_addr[p])) begin
                rd_data[p] = entries[rd_addr[p]];
                if ((BYPASS != 0) && wr_ok && (rd_addr[p] == wr_addr)) begin
                    rd_data[p] = (wr_data & be_mask) | (entries[rd_addr[p]] & ~be_mask);
                end
            end
        end
    end

    assign rd0_data = rd_data[0];
    assign rd1_data = rd_data[1];

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: one default instance (D=32, bypass) and one
// D=24 instance without bypass share the same stimulus.
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset_;
    logic [4:0]  rd0_addr, rd1_addr, wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be_;
    logic        we_, clr_req_;
    logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b;
    logic        busy_a, busy_b;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m0 [32];
    logic [31:0] m1 [24];
    logic [31:0] exp_q [$];

    always #50 clk = ~clk;

    regfile_mp u_a (
        .clk(clk), .reset_(reset_),
        .rd0_addr(rd0_addr), .rd0_data(rd0_a),
        .rd1_addr(rd1_addr), .rd1_data(rd1_a),
        .we_(we_), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be_(wr_be_),
        .clr_req_(clr_req_), .busy(busy_a)
    );

    regfile_mp #(.DATA_D(24), .BYPASS(0)) u_b (
        .clk(clk), .reset_(reset_),
        .rd0_addr(rd0_addr), .rd0_data(rd0_b),
        .rd1_addr(rd1_addr), .rd1_data(rd1_b),
        .we_(we_), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be_(wr_be_),
        .clr_req_(clr_req_), .busy(busy_b)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (!be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input int dut, input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (dut == 0) return m0[a];
        if (a >= 5'd24) return 32'h0;
        return m1[a];
    endfunction

    function automatic void m_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        if (a != 5'd0) m0[a] = merge(m0[a], d, be);
        if (a != 5'd0 && a < 5'd24) m1[a] = merge(m1[a], d, be);
    endfunction

    function automatic void m_zero();
        for (int i = 0; i < 32; i++) m0[i] = 32'h0;
        for (int i = 0; i < 24; i++) m1[i] = 32'h0;
    endfunction

    function automatic logic [31:0] obs(input int p);
        case (p)
            0:       return rd0_a;
            1:       return rd1_a;
            2:       return rd0_b;
            default: return rd1_b;
        endcase
    endfunction

    task automatic push_reads(input logic [4:0] a0, input logic [4:0] a1);
        rd0_addr = a0;
        rd1_addr = a1;
        #1;
        exp_q.push_back(model_rd(0, a0));
        exp_q.push_back(model_rd(0, a1));
        exp_q.push_back(model_rd(1, a0));
        exp_q.push_back(model_rd(1, a1));
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be,
                            input bit accept);
        we_ = 1'b0; wr_addr = a; wr_data = d; wr_be_ = be;
        @(posedge clk); #1;
        we_ = 1'b1; wr_be_ = 4'hF;
        if (accept) m_write(a, d, be);
    endtask

    task automatic fill();
        for (int a = 0; a < 32; a++) do_write(5'(a), 32'(a), 4'h0, 1'b1);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        reset_ = 1'b0; we_ = 1'b1; clr_req_ = 1'b1; wr_be_ = 4'hF;
        wr_addr = '0; wr_data = '0; rd0_addr = '0; rd1_addr = '0;
        m_zero();
        repeat (2) @(posedge clk);
        #1 reset_ = 1'b1;
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++; $display("FAIL reset_busy got a=%b b=%b exp 0", busy_a, busy_b);
        end
        for (int a = 0; a < 32; a++) begin
            push_reads(5'(a), 5'(31 - a));
            for (int p = 0; p < 4; p++) begin
                e = exp_q.pop_front(); checks++;
                if (obs(p) !== e) begin
                    errors++; $display("FAIL reset_read a=%0d port=%0d got=%h exp=%h", a, p, obs(p), e);
                end
            end
        end
    endtask

    task automatic test_byte_mask();
        logic [31:0] e;
        do_write(5'd5, 32'hDEADBEEF, 4'b0000, 1'b1);
        do_write(5'd5, 32'h11223344, 4'b1010, 1'b1);
        push_reads(5'd5, 5'd5);
        for (int p = 0; p < 4; p++) begin
            e = exp_q.pop_front(); checks++;
            if (obs(p) !== e) begin
                errors++; $display("FAIL byte_mask port=%0d got=%h exp=%h", p, obs(p), e);
            end
        end
        checks++;
        if (rd0_a !== 32'hDE22BE44) begin
            errors++; $display("FAIL byte_mask_const got=%h exp=DE22BE44", rd0_a);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] e;
        logic [31:0] d [2];
        logic [3:0]  be [2];
        d[0] = 32'hA5A5A5A5; be[0] = 4'b0000;
        d[1] = 32'h5A5A5A5A; be[1] = 4'b1100;
        do_write(5'd7, 32'h01020304, 4'h0, 1'b1);
        do_write(5'd8, 32'h0BADF00D, 4'h0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            rd0_addr = 5'd7; rd1_addr = 5'd8;
            we_ = 1'b0; wr_addr = 5'd7; wr_data = d[c]; wr_be_ = be[c];
            #1;
            exp_q.push_back(merge(m0[7], d[c], be[c]));
            exp_q.push_back(model_rd(0, 5'd8));
            exp_q.push_back(model_rd(1, 5'd7));
            exp_q.push_back(model_rd(1, 5'd8));
            for (int p = 0; p < 4; p++) begin
                e = exp_q.pop_front(); checks++;
                if (obs(p) !== e) begin
                    errors++; $display("FAIL bypass_same_cycle case=%0d port=%0d got=%h exp=%h", c, p, obs(p), e);
                end
            end
            @(posedge clk); #1;
            we_ = 1'b1; wr_be_ = 4'hF;
            m_write(5'd7, d[c], be[c]);
            push_reads(5'd7, 5'd8);
            for (int p = 0; p < 4; p++) begin
                e = exp_q.pop_front(); checks++;
                if (obs(p) !== e) begin
                    errors++; $display("FAIL bypass_next_cycle case=%0d port=%0d got=%h exp=%h", c, p, obs(p), e);
                end
            end
        end
    endtask

    task automatic test_zero_range();
        logic [31:0] e;
        do_write(5'd0, 32'hFFFFFFFF, 4'h0, 1'b1);
        do_write(5'd30, 32'hFFFFFFFF, 4'h0, 1'b1);
        push_reads(5'd0, 5'd30);
        for (int p = 0; p < 4; p++) begin
            e = exp_q.pop_front(); checks++;
            if (obs(p) !== e) begin
                errors++; $display("FAIL zero_range port=%0d got=%h exp=%h", p, obs(p), e);
            end
        end
    endtask

    task automatic test_clear();
        logic [31:0] e;
        int na, nb, j;
        fill();
        clr_req_ = 1'b0;
        @(posedge clk); #1;
        clr_req_ = 1'b1;
        na = 0; nb = 0; j = 0;
        while ((busy_a || busy_b) && j < 100) begin
            if (j > 0 && j - 1 < 32) m0[j-1] = 32'h0;
            if (j > 0 && j - 1 < 24) m1[j-1] = 32'h0;
            if (busy_a) na++;
            if (busy_b) nb++;
            if (j == 10) begin
                for (int a = 0; a < 32; a++) begin
                    push_reads(5'(a), 5'(31 - a));
                    for (int p = 0; p < 4; p++) begin
                        e = exp_q.pop_front(); checks++;
                        if (obs(p) !== e) begin
                            errors++; $display("FAIL mid_clear a=%0d port=%0d got=%h exp=%h", a, p, obs(p), e);
                        end
                    end
                end
            end
            if (j == 15) begin
                we_ = 1'b0; wr_addr = 5'd3; wr_data = 32'hCAFEF00D; wr_be_ = 4'h0;
            end else begin
                we_ = 1'b1; wr_be_ = 4'hF;
            end
            @(posedge clk); #1;
            j++;
        end
        we_ = 1'b1; wr_be_ = 4'hF;
        m_zero();
        checks++;
        if (na != 32) begin
            errors++; $display("FAIL clear_busy_cycles_a got=%0d exp=32", na);
        end
        checks++;
        if (nb != 24) begin
            errors++; $display("FAIL clear_busy_cycles_b got=%0d exp=24", nb);
        end
        for (int a = 0; a < 32; a++) begin
            push_reads(5'(a), 5'(31 - a));
            for (int p = 0; p < 4; p++) begin
                e = exp_q.pop_front(); checks++;
                if (obs(p) !== e) begin
                    errors++; $display("FAIL after_clear a=%0d port=%0d got=%h exp=%h", a, p, obs(p), e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [31:0] e;
        fill();
        clr_req_ = 1'b0;
        @(posedge clk); #1;
        clr_req_ = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy_a !== 1'b1) begin
            errors++; $display("FAIL mid_clear_busy got=%b exp=1", busy_a);
        end
        rd0_addr = 5'd20; rd1_addr = 5'd12;
        reset_ = 1'b0;
        #1;
        m_zero();
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++; $display("FAIL reset_mid_clear_busy got a=%b b=%b exp 0", busy_a, busy_b);
        end
        checks++;
        if (rd0_a !== 32'h0 || rd1_b !== 32'h0) begin
            errors++; $display("FAIL reset_mid_clear_async got a=%h b=%h exp 0", rd0_a, rd1_b);
        end
        #1 reset_ = 1'b1;
        for (int a = 0; a < 32; a++) begin
            push_reads(5'(a), 5'(31 - a));
            for (int p = 0; p < 4; p++) begin
                e = exp_q.pop_front(); checks++;
                if (obs(p) !== e) begin
                    errors++; $display("FAIL reset_mid_clear_read a=%0d port=%0d got=%h exp=%h", a, p, obs(p), e);
                end
            end
        end
        do_write(5'd3, 32'h12345678, 4'h0, 1'b1);
        push_reads(5'd3, 5'd4);
        for (int p = 0; p < 4; p++) begin
            e = exp_q.pop_front(); checks++;
            if (obs(p) !== e) begin
                errors++; $display("FAIL write_after_reset port=%0d got=%h exp=%h", p, obs(p), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_mask();
        test_bypass();
        test_zero_range();
        test_clear();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
